// File: rtl/ex_mem_stage_ctrl.sv
// EX/MEM pipeline stage: ALU results pass to the MEM/WB boundary in one cycle,
// load/store instructions run over a ready-based data-memory handshake with timeout.
module ex_mem_stage_ctrl #(
  parameter int MAX_WAIT = 15,
  parameter int COUNT_W  = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid_in,
  input  logic        reg_write_enable_in,
  input  logic        mem_enable_in,
  input  logic        mem_rw_in,
  input  logic        mem_to_reg_select_in,
  input  logic        mem_size_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] store_data_in,
  input  logic [3:0]  rd_in,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_byte_en,
  output logic        stall_out,
  output logic        wb_valid_out,
  output logic        reg_write_enable_out,
  output logic        mem_to_reg_select_out,
  output logic [31:0] alu_result_out,
  output logic [31:0] load_data_out,
  output logic [3:0]  rd_out,
  output logic        mem_fault_out,
  output logic        o_dbg_state
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  localparam logic [COUNT_W-1:0] LP_LAST_WAIT = COUNT_W'(MAX_WAIT - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [COUNT_W-1:0] r_cnt;

  // Controls of the memory instruction in flight, replayed at writeback.
  logic        r_lat_rwe;
  logic        r_lat_m2r;
  logic        r_lat_rw;
  logic        r_lat_size;
  logic [31:0] r_lat_alu;
  logic [3:0]  r_lat_rd;

  logic        w_access;
  logic        w_issue;
  logic        w_last_wait;
  logic        w_timeout;
  logic [31:0] w_req_addr;
  logic [3:0]  w_req_be;
  logic [31:0] w_req_wdata;
  logic [7:0]  w_load_byte;

  // Handshake: dmem_req is high from the cycle after issue until the cycle in
  // which dmem_ready=1 is seen (or the wait budget runs out); addr/we/wdata/
  // byte_en are stable while dmem_req is high, and dmem_ready/dmem_rdata are
  // only looked at while dmem_req is high.
  assign w_access    = (r_state == ST_ACCESS);
  assign w_issue     = (r_state == ST_IDLE) && ex_valid_in && mem_enable_in;
  assign w_last_wait = (r_cnt == LP_LAST_WAIT);
  assign w_timeout   = w_access && !dmem_ready && w_last_wait;

  assign dmem_req    = w_access;
  assign o_dbg_state = w_access;
  assign stall_out   = reset && (w_issue || (w_access && !dmem_ready && !w_last_wait));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_issue) w_state_nxt = ST_ACCESS;
      ST_ACCESS: if (dmem_ready || w_last_wait) w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_req_addr  = {alu_result_in[31:2], 2'b00};
    w_req_be    = 4'b1111;
    w_req_wdata = store_data_in;
    if (mem_size_in) begin
      w_req_addr  = alu_result_in;
      w_req_be    = 4'b0001 << alu_result_in[1:0];
      w_req_wdata = {4{store_data_in[7:0]}};
    end
  end

  always_comb begin
    w_load_byte = dmem_rdata[7:0];
    case (r_lat_alu[1:0])
      2'd0: w_load_byte = dmem_rdata[7:0];
      2'd1: w_load_byte = dmem_rdata[15:8];
      2'd2: w_load_byte = dmem_rdata[23:16];
      2'd3: w_load_byte = dmem_rdata[31:24];
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_issue) begin
        r_cnt <= '0;
      end else if (w_access && !dmem_ready && !w_last_wait) begin
        r_cnt <= r_cnt + COUNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wdata   <= '0;
      dmem_byte_en <= '0;
      r_lat_rwe    <= 1'b0;
      r_lat_m2r    <= 1'b0;
      r_lat_rw     <= 1'b0;
      r_lat_size   <= 1'b0;
      r_lat_alu    <= '0;
      r_lat_rd     <= '0;
    end else if (w_issue) begin
      dmem_we      <= mem_rw_in;
      dmem_addr    <= w_req_addr;
      dmem_wdata   <= w_req_wdata;
      dmem_byte_en <= w_req_be;
      r_lat_rwe    <= reg_write_enable_in;
      r_lat_m2r    <= mem_to_reg_select_in;
      r_lat_rw     <= mem_rw_in;
      r_lat_size   <= mem_size_in;
      r_lat_alu    <= alu_result_in;
      r_lat_rd     <= rd_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_valid_out          <= 1'b0;
      reg_write_enable_out  <= 1'b0;
      mem_to_reg_select_out <= 1'b0;
      alu_result_out        <= '0;
      load_data_out         <= '0;
      rd_out                <= '0;
    end else begin
      wb_valid_out         <= 1'b0;
      reg_write_enable_out <= 1'b0;
      if (r_state == ST_IDLE) begin
        if (ex_valid_in && !mem_enable_in) begin
          wb_valid_out          <= 1'b1;
          reg_write_enable_out  <= reg_write_enable_in;
          mem_to_reg_select_out <= mem_to_reg_select_in;
          alu_result_out        <= alu_result_in;
          rd_out                <= rd_in;
        end
      end else if (dmem_ready || w_timeout) begin
        // A timed-out access still retires, but never writes the register file.
        wb_valid_out          <= 1'b1;
        reg_write_enable_out  <= dmem_ready ? r_lat_rwe : 1'b0;
        mem_to_reg_select_out <= r_lat_m2r;
        alu_result_out        <= r_lat_alu;
        rd_out                <= r_lat_rd;
        if (dmem_ready && !r_lat_rw) begin
          load_data_out <= r_lat_size ? {24'b0, w_load_byte} : dmem_rdata;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_fault_out <= 1'b0;
    end else if (w_timeout) begin
      mem_fault_out <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ex_mem_stage_ctrl.sv
// Bench for ex_mem_stage_ctrl: transaction-level reference model, per-cycle
// compare process, directed scenarios plus randomized instruction stream.
module tb_ex_mem_stage_ctrl;
  localparam int MAX_WAIT = 15;
  localparam int W        = 39;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic        ex_valid_in          = 1'b0;
  logic        reg_write_enable_in  = 1'b0;
  logic        mem_enable_in        = 1'b0;
  logic        mem_rw_in            = 1'b0;
  logic        mem_to_reg_select_in = 1'b0;
  logic        mem_size_in          = 1'b0;
  logic [31:0] alu_result_in        = '0;
  logic [31:0] store_data_in        = '0;
  logic [3:0]  rd_in                = '0;
  logic        dmem_ready           = 1'b0;
  logic [31:0] dmem_rdata           = '0;

  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_byte_en;
  logic        stall_out;
  logic        wb_valid_out;
  logic        reg_write_enable_out;
  logic        mem_to_reg_select_out;
  logic [31:0] alu_result_out;
  logic [31:0] load_data_out;
  logic [3:0]  rd_out;
  logic        mem_fault_out;
  logic        o_dbg_state;

  ex_mem_stage_ctrl #(.MAX_WAIT(MAX_WAIT), .COUNT_W(8)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .ex_valid_in           (ex_valid_in),
    .reg_write_enable_in   (reg_write_enable_in),
    .mem_enable_in         (mem_enable_in),
    .mem_rw_in             (mem_rw_in),
    .mem_to_reg_select_in  (mem_to_reg_select_in),
    .mem_size_in           (mem_size_in),
    .alu_result_in         (alu_result_in),
    .store_data_in         (store_data_in),
    .rd_in                 (rd_in),
    .dmem_ready            (dmem_ready),
    .dmem_rdata            (dmem_rdata),
    .dmem_req              (dmem_req),
    .dmem_we               (dmem_we),
    .dmem_addr             (dmem_addr),
    .dmem_wdata            (dmem_wdata),
    .dmem_byte_en          (dmem_byte_en),
    .stall_out             (stall_out),
    .wb_valid_out          (wb_valid_out),
    .reg_write_enable_out  (reg_write_enable_out),
    .mem_to_reg_select_out (mem_to_reg_select_out),
    .alu_result_out        (alu_result_out),
    .load_data_out         (load_data_out),
    .rd_out                (rd_out),
    .mem_fault_out         (mem_fault_out),
    .o_dbg_state           (o_dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: one outstanding memory op, counted in ACCESS cycles
  logic        m_busy  = 1'b0;
  logic        m_wb    = 1'b0;
  logic        m_fault = 1'b0;
  int          m_wait  = 0;
  logic [31:0] m_load  = '0;
  logic        m_rwe = 1'b0, m_m2r = 1'b0, m_rw = 1'b0, m_sz = 1'b0;
  logic [31:0] m_alu = '0, m_addr = '0, m_wdata = '0;
  logic [3:0]  m_rd = '0, m_be = '0;
  // record: {check_data, reg_write, mem_to_reg, rd[3:0], alu[31:0]}
  logic [W-1:0] exp_q[$];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy = 1'b0; m_wb = 1'b0; m_fault = 1'b0; m_wait = 0; m_load = '0;
      exp_q.delete();
    end else if (!m_busy) begin
      m_wb = 1'b0;
      if (ex_valid_in && mem_enable_in) begin
        m_busy = 1'b1; m_wait = 0;
        m_rwe = reg_write_enable_in; m_m2r = mem_to_reg_select_in;
        m_rw = mem_rw_in; m_sz = mem_size_in; m_alu = alu_result_in; m_rd = rd_in;
        m_addr  = mem_size_in ? alu_result_in : (alu_result_in & 32'hFFFF_FFFC);
        m_be    = mem_size_in ? (4'b0001 << alu_result_in[1:0]) : 4'b1111;
        m_wdata = mem_size_in ? ({24'b0, store_data_in[7:0]} * 32'h0101_0101) : store_data_in;
      end else if (ex_valid_in) begin
        m_wb = 1'b1;
        exp_q.push_back({1'b1, reg_write_enable_in, mem_to_reg_select_in, rd_in, alu_result_in});
      end
    end else begin
      m_wait++;
      if (dmem_ready) begin
        m_busy = 1'b0; m_wb = 1'b1;
        if (!m_rw) m_load = m_sz ? ((dmem_rdata >> (8 * m_alu[1:0])) & 32'hFF) : dmem_rdata;
        exp_q.push_back({1'b1, m_rwe, m_m2r, m_rd, m_alu});
      end else if (m_wait == MAX_WAIT) begin
        m_busy = 1'b0; m_wb = 1'b1; m_fault = 1'b1;
        exp_q.push_back({1'b0, 1'b0, m_m2r, m_rd, m_alu});
      end else begin
        m_wb = 1'b0;
      end
    end
  end

  // scoreboard compare, once per cycle on the falling edge
  always @(negedge clk) begin
    logic         exp_stall;
    logic [W-1:0] rec;
    if (!reset)       exp_stall = 1'b0;
    else if (!m_busy) exp_stall = ex_valid_in && mem_enable_in;
    else              exp_stall = !dmem_ready && (m_wait + 1 < MAX_WAIT);
    chk("stall_out", {31'b0, stall_out}, {31'b0, exp_stall});
    chk("dmem_req", {31'b0, dmem_req}, {31'b0, m_busy});
    chk("wb_valid", {31'b0, wb_valid_out}, {31'b0, m_wb});
    chk("mem_fault", {31'b0, mem_fault_out}, {31'b0, m_fault});
    chk("load_data", load_data_out, m_load);
    if (m_busy) begin
      chk("dmem_addr", dmem_addr, m_addr);
      chk("dmem_we", {31'b0, dmem_we}, {31'b0, m_rw});
      chk("dmem_be", {28'b0, dmem_byte_en}, {28'b0, m_be});
      chk("dmem_wdata", dmem_wdata, m_wdata);
    end
    if (m_wb) begin
      chk("wb_queue_nonempty", {31'b0, (exp_q.size() != 0)}, 32'd1);
      if (exp_q.size() != 0) begin
        rec = exp_q.pop_front();
        chk("reg_write_out", {31'b0, reg_write_enable_out}, {31'b0, rec[37]});
        if (rec[38]) begin
          chk("mem_to_reg_out", {31'b0, mem_to_reg_select_out}, {31'b0, rec[36]});
          chk("rd_out", {28'b0, rd_out}, {28'b0, rec[35:32]});
          chk("alu_result_out", alu_result_out, rec[31:0]);
        end
      end
    end else begin
      chk("reg_write_bubble", {31'b0, reg_write_enable_out}, 32'd0);
    end
  end

  // driver: upstream pipeline honours stall_out, memory responder answers after plan_lat waits
  logic        hold = 1'b0, req_seen = 1'b0;
  logic [31:0] snap_addr = '0, snap_wdata = '0;
  logic [3:0]  snap_be = '0;
  logic        snap_we = 1'b0;
  int          plan_lat = 0, acc_cnt = 0;
  logic        plan_fixed = 1'b0;
  logic [31:0] plan_rdata = '0;

  task automatic cycle();
    @(negedge clk);
    hold = stall_out;
    req_seen = dmem_req;
    if (dmem_req) begin
      snap_addr = dmem_addr; snap_wdata = dmem_wdata; snap_be = dmem_byte_en; snap_we = dmem_we;
    end
    @(posedge clk);
    #1;
    if (dmem_req) begin
      dmem_ready = (acc_cnt == plan_lat);
      dmem_rdata = plan_fixed ? plan_rdata : $urandom;
      acc_cnt++;
    end else begin
      dmem_ready = 1'b0;
      dmem_rdata = $urandom;
      acc_cnt = 0;
    end
  endtask

  task automatic send(input logic v, input logic rwe, input logic men, input logic rw,
                      input logic m2r, input logic sz, input logic [31:0] alu,
                      input logic [31:0] sd, input logic [3:0] rd, input int lat,
                      input logic fixed, input logic [31:0] rdata,
                      output int n_stall, output int n_req);
    int budget;
    ex_valid_in = v; reg_write_enable_in = rwe; mem_enable_in = men; mem_rw_in = rw;
    mem_to_reg_select_in = m2r; mem_size_in = sz; alu_result_in = alu;
    store_data_in = sd; rd_in = rd;
    plan_lat = lat; plan_fixed = fixed; plan_rdata = rdata;
    n_stall = 0; n_req = 0; budget = 0;
    do begin
      cycle();
      if (hold) n_stall++;
      if (req_seen) n_req++;
      budget++;
    end while (hold && budget < 40);
    chk("stall_budget", {31'b0, hold}, 32'd0);
  endtask

  initial begin
    int ns, nr;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dmem_req", {31'b0, dmem_req}, 32'd0);
    chk("rst_stall", {31'b0, stall_out}, 32'd0);
    chk("rst_wb_valid", {31'b0, wb_valid_out}, 32'd0);
    chk("rst_fault", {31'b0, mem_fault_out}, 32'd0);
    chk("rst_dmem_addr", dmem_addr, 32'd0);
    chk("rst_byte_en", {28'b0, dmem_byte_en}, 32'd0);
    chk("rst_load_data", load_data_out, 32'd0);
    reset = 1'b1;

    // ALU passthrough
    send(1, 1, 0, 0, 0, 0, 32'h0000_00A5, 32'h0, 4'd3, 0, 0, 32'h0, ns, nr);
    chk("pass_stall_cycles", ns, 0);
    chk("pass_wb_valid", {31'b0, wb_valid_out}, 32'd1);
    chk("pass_alu", alu_result_out, 32'h0000_00A5);
    chk("pass_rd", {28'b0, rd_out}, 32'd3);
    chk("pass_rwe", {31'b0, reg_write_enable_out}, 32'd1);

    // word load at 0x1003, ready on the 3rd ACCESS cycle
    send(1, 1, 1, 0, 1, 0, 32'h0000_1003, 32'h0, 4'd5, 2, 1, 32'hDEAD_BEEF, ns, nr);
    chk("wload_stall_cycles", ns, 3);
    chk("wload_addr", snap_addr, 32'h0000_1000);
    chk("wload_be", {28'b0, snap_be}, 32'hF);
    chk("wload_data", load_data_out, 32'hDEAD_BEEF);
    chk("wload_wb_valid", {31'b0, wb_valid_out}, 32'd1);
    chk("wload_rd", {28'b0, rd_out}, 32'd5);

    // byte store at 0x2002, ready on first ACCESS cycle
    send(1, 0, 1, 1, 0, 1, 32'h0000_2002, 32'h1234_56C3, 4'd0, 0, 0, 32'h0, ns, nr);
    chk("bstore_stall_cycles", ns, 1);
    chk("bstore_be", {28'b0, snap_be}, 32'h4);
    chk("bstore_wdata", snap_wdata, 32'hC3C3_C3C3);
    chk("bstore_we", {31'b0, snap_we}, 32'd1);
    chk("bstore_load_hold", load_data_out, 32'hDEAD_BEEF);

    // byte load at 0x11
    send(1, 1, 1, 0, 1, 1, 32'h0000_0011, 32'h0, 4'd7, 1, 1, 32'hAABB_CCDD, ns, nr);
    chk("bload_data", load_data_out, 32'h0000_00CC);

    // timeout with dmem_ready held low
    send(1, 1, 1, 0, 1, 0, 32'h0000_0040, 32'h0, 4'd9, 255, 0, 32'h0, ns, nr);
    chk("tmo_req_cycles", nr, MAX_WAIT);
    chk("tmo_stall_cycles", ns, MAX_WAIT);
    chk("tmo_fault", {31'b0, mem_fault_out}, 32'd1);
    chk("tmo_wb_valid", {31'b0, wb_valid_out}, 32'd1);
    chk("tmo_rwe", {31'b0, reg_write_enable_out}, 32'd0);

    // a normal load afterwards leaves the fault set
    send(1, 1, 1, 0, 1, 0, 32'h0000_0080, 32'h0, 4'd2, 0, 1, 32'h600D_F00D, ns, nr);
    chk("post_tmo_fault", {31'b0, mem_fault_out}, 32'd1);
    chk("post_tmo_data", load_data_out, 32'h600D_F00D);
    chk("post_tmo_rwe", {31'b0, reg_write_enable_out}, 32'd1);

    send(0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 4'd0, 0, 0, 32'h0, ns, nr);
    chk("bubble_wb_valid", {31'b0, wb_valid_out}, 32'd0);

    // randomized instruction stream
    for (int i = 0; i < 400; i++) begin
      logic v, rwe, men, rw, m2r, sz;
      int r, lat;
      v   = ($urandom_range(0, 9) != 0);
      rwe = 1'($urandom_range(0, 1));
      men = 1'($urandom_range(0, 1));
      rw  = 1'($urandom_range(0, 1));
      m2r = 1'($urandom_range(0, 1));
      sz  = 1'($urandom_range(0, 1));
      r   = int'($urandom_range(0, 19));
      lat = (r < 15) ? int'($urandom_range(0, 3)) : int'($urandom_range(12, 20));
      send(v, rwe, men, rw, m2r, sz, $urandom, $urandom, 4'($urandom_range(0, 15)),
           lat, 0, 32'h0, ns, nr);
    end

    // reset asserted in the middle of an access
    ex_valid_in = 1'b1; mem_enable_in = 1'b1; reg_write_enable_in = 1'b1;
    mem_rw_in = 1'b0; mem_size_in = 1'b0; alu_result_in = 32'h0000_0300; rd_in = 4'd4;
    plan_lat = 255; plan_fixed = 1'b0;
    repeat (3) cycle();
    chk("mid_req_before", {31'b0, dmem_req}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_req", {31'b0, dmem_req}, 32'd0);
    chk("mid_rst_stall", {31'b0, stall_out}, 32'd0);
    chk("mid_rst_wb_valid", {31'b0, wb_valid_out}, 32'd0);
    chk("mid_rst_fault", {31'b0, mem_fault_out}, 32'd0);
    chk("mid_rst_addr", dmem_addr, 32'd0);
    chk("mid_rst_load", load_data_out, 32'd0);
    chk("mid_rst_alu", alu_result_out, 32'd0);
    cycle();
    ex_valid_in = 1'b0; mem_enable_in = 1'b0;
    #2 reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("post_rst_wb_valid", {31'b0, wb_valid_out}, 32'd0);
      chk("post_rst_req", {31'b0, dmem_req}, 32'd0);
    end
    chk("exp_q_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage_ctrl.md
Name: ex_mem_stage_ctrl

Overview:
- EX/MEM pipeline stage. Sits directly downstream of id_ex_reg and the ALU, and consumes their registered control signals and the ALU result.
- Non-memory instructions pass to the MEM/WB boundary with 1-cycle latency.
- Memory instructions (load/store, word or byte) are issued over a ready-based data-memory handshake. The stage raises stall_out to freeze the upstream pipeline until the access completes or times out.

Parameters:
- MAX_WAIT, 15: maximum ACCESS cycles without dmem_ready before the access is aborted (1..255).
- COUNT_W, 8: width of the wait counter.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low (0 = reset asserted)
- ex_valid_in  in  1  valid instruction present in EX
- reg_write_enable_in  in  1  from id_ex_reg
- mem_enable_in  in  1  instruction accesses memory
- mem_rw_in  in  1  1 = store, 0 = load
- mem_to_reg_select_in  in  1  WB selects load data
- mem_size_in  in  1  0 = word, 1 = byte
- alu_result_in  in  32  address or ALU result
- store_data_in  in  32  Rd value for stores
- rd_in  in  4  destination register
- dmem_ready  in  1  memory completes access this cycle
- dmem_rdata  in  32  load data, valid when dmem_ready=1
- dmem_req  out  1  request active
- dmem_we  out  1  write enable
- dmem_addr  out  32  access address
- dmem_wdata  out  32  store data
- dmem_byte_en  out  4  lane enables, little-endian
- stall_out  out  1  hold IF/ID and ID/EX this cycle
- wb_valid_out  out  1  valid result at WB boundary
- reg_write_enable_out  out  1  registered
- mem_to_reg_select_out  out  1  registered
- alu_result_out  out  32  registered
- load_data_out  out  32  registered, zero-extended for byte loads
- rd_out  out  4  registered
- mem_fault_out  out  1  sticky timeout flag

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, wait counter=0.
  - Every registered output = 0, including dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_byte_en, wb_valid_out and mem_fault_out.
  - An in-flight access is abandoned immediately. No completion is reported after reset releases.
- States: IDLE, ACCESS.
- dmem_* outputs are driven from registers only. dmem_req = (state==ACCESS).
- stall_out is combinational:
  - 1 when state=IDLE and ex_valid_in=1 and mem_enable_in=1.
  - 1 when state=ACCESS and dmem_ready=0 and the timeout is not reached.
  - 0 otherwise.
- IDLE, ex_valid_in=0:
  - Bubble: next cycle wb_valid_out=0 and reg_write_enable_out=0.
  - Other data outputs hold their values.
- IDLE, ex_valid_in=1, mem_enable_in=0:
  - Next cycle wb_valid_out=1; all control and data inputs are registered to their outputs.
  - load_data_out holds its value.
- IDLE, ex_valid_in=1, mem_enable_in=1:
  - Latch request registers and the control signals. Move to ACCESS. Counter=0.
  - Next cycle wb_valid_out=0 and reg_write_enable_out=0.
- Request formation:
  - Word access: dmem_addr={alu_result_in[31:2],2'b00}, byte_en=4'b1111, dmem_wdata=store_data_in.
  - Byte access: dmem_addr=alu_result_in, byte_en=4'b0001<<alu_result_in[1:0], dmem_wdata = store_data_in[7:0] replicated in all four lanes.
  - dmem_we=mem_rw_in.
- ACCESS, dmem_ready=0:
  - Counter increments each cycle. Bubble to WB.
  - When the counter reaches MAX_WAIT-1 (i.e. the MAX_WAIT-th ACCESS cycle), this cycle counts as the timeout cycle.
- ACCESS, dmem_ready=1 (takes priority over timeout in the same cycle):
  - Go to IDLE. stall_out=0 this cycle.
  - Next cycle wb_valid_out=1 with the latched controls, alu_result and rd.
  - Load word: load_data_out=dmem_rdata.
  - Load byte: load_data_out={24'b0, dmem_rdata byte selected by addr[1:0]}.
  - Store: load_data_out holds its value.
- Timeout:
  - Go to IDLE. stall_out=0. mem_fault_out=1 (sticky until reset).
  - Next cycle wb_valid_out=1 with reg_write_enable_out=0 (writeback suppressed).
- Load latency: request cycle T, dmem_req high from T+1, dmem_ready seen at T+1+k, result visible at T+2+k.

Test Plan:
- ALU passthrough: ex_valid=1, mem_enable=0, alu_result=0x0000_00A5, rd=3, reg_write=1 -> next cycle wb_valid=1, alu_result_out=0xA5, rd_out=3; stall_out never 1.
- Word load at addr 0x1003, dmem_ready on 3rd ACCESS cycle with rdata 0xDEADBEEF:
  - dmem_addr=0x1000, byte_en=1111.
  - stall_out=1 for 3 cycles.
  - load_data_out=0xDEADBEEF one cycle after ready.
- Byte store at addr 0x2002, store_data=0x123456C3:
  - byte_en=0100, dmem_wdata=0xC3C3C3C3, dmem_we=1.
  - Ready on first ACCESS cycle -> exactly 1 stall cycle.
- Byte load at addr 0x11, rdata 0xAABBCCDD -> load_data_out=0x000000CC.
- Timeout, dmem_ready held 0:
  - dmem_req high for exactly MAX_WAIT=15 cycles.
  - mem_fault_out=1; wb_valid_out=1 with reg_write_enable_out=0.
  - A later normal load does not clear mem_fault_out.
- Reset asserted mid-ACCESS:
  - dmem_req, stall_out and all outputs go to 0 without a clock edge.
  - After release, no wb_valid_out until a new instruction arrives.
